reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Sequences the active-high clear inputs of up to NCHAN banks of asynchronous-clear flip-flops (FDCE-based). All selected banks are held in clear for a fixed hold time, then released one at a time in ascending channel order with a fixed gap between releases. It runs once after power-on reset and again on each software request. It sits in the northbridge clocking/reset block and drives the clr pins of the downstream flip-flop banks.

Parameters:
NCHAN, 4, number of clear channels (1..8)
HOLD_CYCLES, 16, clk cycles during which all selected clr outputs stay asserted (>=1)
GAP_CYCLES, 8, clk cycles between consecutive channel releases (>=1)
CNT_W, 8, counter width; HOLD_CYCLES and GAP_CYCLES must each be < 2**CNT_W

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req  input  1  request a clear sequence; sampled only in IDLE
chan_mask  input  NCHAN  channels to include in the requested sequence; latched on the accepting edge
clr  output  NCHAN  registered active-high clears to the flip-flop banks
busy  output  1  high while a sequence is in progress
done  output  1  one-cycle pulse marking the end of a sequence

Behaviour:
- All outputs are registered. States: IDLE, HOLD, RELEASE.
- Reset (edge sampling reset=1): clr=all ones, busy=1, done=0, state=HOLD, count=0, pending=all ones. The power-on sequence covers all channels.
- E0 is the accepting edge. For reset, E0 is the last edge at which reset is sampled high. For a request, E0 is the edge at which IDLE samples req=1 with chan_mask!=0.
- At an IDLE accept (E0):
  - pending<=chan_mask, clr<=chan_mask, busy<=1, state<=HOLD, count<=0.
  - Unmasked clr bits remain 0 throughout the sequence.
- HOLD: count increments each edge. At edge E0+HOLD_CYCLES, the lowest set bit of pending is cleared in both clr and pending. The state moves to RELEASE with count reset.
- RELEASE: after a release, the next lowest pending channel is released exactly GAP_CYCLES edges later. Masked channels cost zero cycles, so the j-th selected channel (j from 0) falls at E0+HOLD_CYCLES+j*GAP_CYCLES.
- The edge that releases the last pending channel also sets done=1 and busy=0, and moves the state to IDLE. done returns to 0 on the next edge.
- req=1 with chan_mask=0 in IDLE: clr unchanged, busy stays 0, done pulses for one cycle after that edge.
- req while busy: ignored and not queued. A chan_mask change mid-sequence has no effect.
- In IDLE, clr=0 and busy=0.
- Reset mid-sequence: the next edge forces the reset values and restarts the full power-on sequence. No done pulse is generated for the aborted sequence.
- NCHAN=1: a single release at E0+HOLD_CYCLES, with done on the same edge.

Optional Feature:
RESET_SEQ_DEBOUNCE_EN:
- Defined: req is accepted only when sampled high in IDLE on 3 consecutive edges. E0 is the third of those edges, and chan_mask is latched at E0. A debounce counter clears whenever req=0, when not in IDLE, and on reset.
- Undefined: single-edge acceptance as described above. No debounce logic is generated.

Test Plan:
- Power-on (NCHAN=4, HOLD=16, GAP=8): reset high 3 cycles, last high edge L -> clr=4'b1111 from reset; clr[0] falls L+16, clr[1] L+24, clr[2] L+32, clr[3] L+40; done=1 only during the cycle after L+40; busy=0 after L+40.
- Masked request: IDLE, req=1 with chan_mask=4'b1010 at edge E -> clr=4'b1010 after E; clr[1] falls E+16, clr[3] falls E+24; clr[0] and clr[2] never assert; done pulses at E+24.
- Busy ignore: during the scenario-2 sequence, pulse req with chan_mask=4'b1111 at E+5 -> timing identical to scenario 2, and no second sequence follows.
- Empty mask: req=1 with chan_mask=0 at E -> clr stays 0, busy stays 0, done=1 for exactly one cycle after E.
- Reset mid-sequence: in scenario 2, assert reset for 1 cycle at edge E+20 -> clr=4'b1111 after E+20 and no done pulse; the power-on timing of scenario 1 follows with L=E+20.
- Debounce (RESET_SEQ_DEBOUNCE_EN defined): req high for 2 edges then low -> no sequence; req high for 3 edges with the third at E -> scenario-2 timing relative to E.

Source files
------------

// File: rtl/reset_sequencer.sv
// Clear sequencer for FDCE flip-flop banks: hold all selected clears, then release them in ascending order.
// Optional build macro RESET_SEQ_DEBOUNCE_EN: req must be seen high in IDLE on 3 consecutive edges.

module reset_sequencer_lane (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic mask_bit,
  input  logic rel_bit,
  output logic clr
);
  always_ff @(posedge clk) begin
    if (reset)        clr <= 1'b1;
    else if (load)    clr <= mask_bit;
    else if (rel_bit) clr <= 1'b0;
  end
endmodule

module reset_sequencer #(
  parameter int NCHAN       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [NCHAN-1:0] chan_mask,
  output logic [NCHAN-1:0] clr,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [NCHAN-1:0]   pending, pending_n;
  logic [NCHAN-1:0]   lowbit;
  logic               busy_n, done_n;
  logic               load, rel, accept;

  assign lowbit = pending & (~pending + NCHAN'(1));

`ifdef RESET_SEQ_DEBOUNCE_EN
  logic [1:0] db_cnt;

  // Counts consecutive IDLE edges with req high; third one accepts.
  always_ff @(posedge clk) begin
    if (reset || state != IDLE || !req) db_cnt <= 2'd0;
    else if (db_cnt == 2'd2)            db_cnt <= 2'd0;
    else                                db_cnt <= db_cnt + 2'd1;
  end

  assign accept = req && (db_cnt == 2'd2);
`else
  assign accept = req;
`endif

  always_comb begin
    state_n   = state;
    count_n   = count;
    pending_n = pending;
    busy_n    = busy;
    done_n    = 1'b0;
    load      = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (accept) begin
          if (chan_mask != '0) begin
            load      = 1'b1;
            pending_n = chan_mask;
            busy_n    = 1'b1;
            state_n   = HOLD;
            count_n   = '0;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      HOLD, RELEASE: begin
        if (count == ((state == HOLD) ? HOLD_M1 : GAP_M1)) begin
          rel       = 1'b1;
          pending_n = pending & ~lowbit;
          count_n   = '0;
          if (pending_n == '0) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = RELEASE;
          end
        end else begin
          count_n = count + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HOLD;
      count   <= '0;
      pending <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      pending <= pending_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // clr tracks pending per channel; each lane drops on its own release strobe.
  for (genvar i = 0; i < NCHAN; i++) begin : g_lane
    reset_sequencer_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .mask_bit (chan_mask[i]),
      .rel_bit  (rel & lowbit[i]),
      .clr      (clr[i])
    );
  end
endmodule
